// File: rtl/jtframe_info_probe_pkg.sv
// Shared constants and types for the target-info debug probe.
// Covers the analysis modes, the debug_bus field layout and the capture states.
package jtframe_info_pkg;

  localparam logic [1:0] INFO_LIVE = 2'd0;
  localparam logic [1:0] INFO_PEAK = 2'd1;
  localparam logic [1:0] INFO_CNT  = 2'd2;
  localparam logic [1:0] INFO_CAP  = 2'd3;

  localparam int DB_MODE_LSB = 6;
  localparam int DB_BYTE_BIT = 5;
  localparam int DB_CH_MSB   = 4;

  typedef enum logic {ARMED = 1'b0, HELD = 1'b1} cap_state_e;

  // The byte-select bit is left out so that flipping it never restarts the trackers.
  function automatic logic [6:0] sel_key(input logic [7:0] db);
    return {db[7:DB_MODE_LSB], db[DB_CH_MSB:0]};
  endfunction

endpackage

// File: rtl/jtframe_info_probe_if.sv
// Bus between the debug display logic and the probe.
// It carries the channel inputs, the debug_bus control byte and the displayed byte.
interface jtframe_info_probe_if #(
  parameter int CH = 16,
  parameter int W  = 16
);
  logic [CH*W-1:0] ch_data;
  logic            trig;
  logic            LVBL;
  logic [7:0]      debug_bus;
  logic [7:0]      target_info;
  logic            info_hold;

  modport master (output ch_data, trig, LVBL, debug_bus, input target_info, info_hold);
  modport slave  (input ch_data, trig, LVBL, debug_bus, output target_info, info_hold);
endinterface

// File: rtl/jtframe_info_probe_track.sv
// Per-channel analysis trackers: unsigned peak, saturating transition count and one-shot capture.
// Every tracker restarts on clr.
module jtframe_info_track
  import jtframe_info_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        cap_en,
  input  logic        trig,
  input  logic [15:0] sample,
  input  logic [15:0] prev,
  output logic [15:0] peak,
  output logic [15:0] count,
  output logic [15:0] hold,
  output logic        held
);

  cap_state_e st;
  logic       prev_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      peak    <= '0;
      count   <= '0;
      hold    <= '0;
      st      <= ARMED;
      prev_ok <= 1'b0;
    end else if (clr) begin
      peak    <= '0;
      count   <= '0;
      hold    <= '0;
      st      <= ARMED;
      prev_ok <= 1'b0;
    end else begin
      // In the first cycle after clr, prev still holds data from the old channel.
      prev_ok <= 1'b1;
      if (sample > peak) peak <= sample;
      if (prev_ok && sample != prev && count != 16'hFFFF) count <= count + 16'd1;
      if (st == ARMED && cap_en && trig) begin
        hold <= sample;
        st   <= HELD;
      end
    end
  end

  assign held = (st == HELD);

endmodule

// File: rtl/jtframe_info_probe.sv
// Debug probe that selects one channel, runs trackers on it and shows a chosen byte as target_info.
// The display can refresh every cycle or only on the falling edge of LVBL.
module jtframe_info_probe
  import jtframe_info_pkg::*;
#(
  parameter int CH    = 16,
  parameter int W     = 16,
  parameter int VBUPD = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  jtframe_info_probe_if.slave bus
);

  logic [7:0]  sel_q;
  logic        clr;
  logic [1:0]  mode;
  logic [15:0] sel_ch, sample_q, prev_q, value;
  logic [15:0] peak, count, hold;
  logic        held;
  logic        lvbl_q, upd;
  logic [7:0]  byte_sel, info_q;

  assign mode = bus.debug_bus[7:DB_MODE_LSB];
  assign clr  = sel_key(bus.debug_bus) != sel_key(sel_q);

  always_comb begin
    // NOTE: assigning a default first keeps this combinational; otherwise missed paths infer a latch.
    sel_ch = '0;
    for (int k = 0; k < CH; k++)
      if (bus.debug_bus[DB_CH_MSB:0] == 5'(k)) sel_ch[W-1:0] = bus.ch_data[k*W +: W];
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q    <= '0;
      sample_q <= '0;
      prev_q   <= '0;
      lvbl_q   <= 1'b0;
    end else begin
      sel_q    <= bus.debug_bus;
      sample_q <= sel_ch;
      prev_q   <= sample_q;
      lvbl_q   <= bus.LVBL;
    end
  end

  jtframe_info_track u_track (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (clr),
    .cap_en (mode == INFO_CAP),
    .trig   (bus.trig),
    .sample (sample_q),
    .prev   (prev_q),
    .peak   (peak),
    .count  (count),
    .hold   (hold),
    .held   (held)
  );

  always_comb begin
    value = sample_q;
    case (mode)
      INFO_PEAK: value = peak;
      INFO_CNT:  value = count;
      INFO_CAP:  value = held ? hold : sample_q;
      default:   value = sample_q;
    endcase
  end

  assign byte_sel = bus.debug_bus[DB_BYTE_BIT] ? value[15:8] : value[7:0];
  assign upd      = (VBUPD == 0) ? 1'b1 : (lvbl_q & ~bus.LVBL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   info_q <= '0;
    else if (upd) info_q <= byte_sel;
  end

  assign bus.target_info = info_q;
  assign bus.info_hold   = held;

endmodule
